// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared state encoding and framing constants for the boot loader
package boot_loader_pkg;

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        DONE,
        ERR
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic accepts_bytes(input state_e s);
        return (s == CNT_LO) || (s == CNT_HI) || (s == DATA);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master: stream source / memory observer; slave: the loader
    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// rtl/imem_boot_loader_word_packer.sv - assembles little-endian bytes into 32-bit words
module boot_word_packer
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word_data
);
    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    assign byte_last  = (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_valid = valid_q;
    assign word_data  = word_q;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (byte_valid) begin
            // earlier bytes drift toward bit 0, so b0 ends up in the low lane
            shift_d = {byte_data, shift_q[23:8]};
            idx_d   = idx_q + 2'd1;
            if (byte_last) begin
                word_d  = {byte_data, shift_q};
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a counted word image into imem, then releases the CPU
module imem_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_rst_n,
    output logic                done,
    output logic                error
);
    state_e            state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       hdr;
    logic              pk_last;
    logic              pk_word_valid;
    logic [31:0]       pk_word;

    assign accept = bus.in_valid && in_ready_q;
    assign hdr    = {bus.in_data, cnt_lo_q};

    boot_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (accept && (state_q == DATA)),
        .byte_data  (bus.in_data),
        .byte_last  (pk_last),
        .word_valid (pk_word_valid),
        .word_data  (pk_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_lo_d = cnt_lo_q;
        count_d  = count_q;
        widx_d   = widx_q;
        addr_d   = addr_q;
        case (state_q)
            CNT_LO: begin
                if (accept) begin
                    cnt_lo_d = bus.in_data;
                    state_d  = CNT_HI;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    count_d = hdr;
                    if (hdr == 16'd0)
                        state_d = DONE;
                    else if ({16'd0, hdr} > 32'(DEPTH))
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                // widx_q already counts the word being written this cycle
                if (pk_word_valid && (16'(widx_q) == count_q))
                    state_d = DONE;
                if (accept && pk_last) begin
                    addr_d = widx_q[ADDR_W-1:0];
                    widx_d = widx_q + 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // stop taking bytes once the final word's last byte is in
    always_comb begin
        in_ready_d = accepts_bytes(state_d) &&
                     !((state_d == DATA) && (16'(widx_d) == count_d));
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CNT_LO;
            cnt_lo_q   <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            addr_q     <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_lo_q   <= cnt_lo_d;
            count_q    <= count_d;
            widx_q     <= widx_d;
            addr_q     <= addr_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = pk_word_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = pk_word;
    assign cpu_rst_n      = done_q;
    assign done           = done_q;
    assign error          = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized self-checking bench against a stream-level model
module tb_imem_boot_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_rst_n, done, error;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory-side observer
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    int                last_we_cyc = -1;
    int                done_rise_cyc = -1;
    logic              prev_done = 1'b0;
    always @(negedge clk) begin
        if (bus.imem_we) begin
            got_addr.push_back(bus.imem_addr);
            got_data.push_back(bus.imem_wdata);
            last_we_cyc = cyc;
        end
        if (done && !prev_done) done_rise_cyc = cyc;
        prev_done = done;
    end

    logic [7:0]        stim[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic              exp_done, exp_err;
    int                base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // model: the header decides everything; words are bytes taken LSB first
    task automatic build_expected();
        int cnt;
        exp_addr.delete();
        exp_data.delete();
        cnt      = int'(stim[0]) + 256 * int'(stim[1]);
        exp_err  = (cnt > DEPTH);
        exp_done = !exp_err;
        if (!exp_err) begin
            for (int w = 0; w < cnt; w++) begin
                exp_addr.push_back(w[ADDR_W-1:0]);
                exp_data.push_back({stim[2+4*w+3], stim[2+4*w+2], stim[2+4*w+1], stim[2+4*w]});
            end
        end
    endtask

    task automatic drive(input int bubble_pct);
        int i = 0;
        int guard = 0;
        while (i < stim.size() && guard < 20000) begin
            bus.in_valid = ($urandom_range(99) >= bubble_pct);
            bus.in_data  = bus.in_valid ? stim[i] : 8'($urandom);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (i < stim.size()) check("drive_timeout", i, stim.size());
    endtask

    task automatic apply_reset(input bit check_state);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (2) @(negedge clk);
        if (check_state) begin
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_we", bus.imem_we, 0);
            check("rst_addr", 32'(bus.imem_addr), 0);
            check("rst_wdata", bus.imem_wdata, 0);
            check("rst_cpu_rst_n", cpu_rst_n, 0);
            check("rst_done", done, 0);
            check("rst_error", error, 0);
        end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int bubble_pct);
        base = got_addr.size();
        build_expected();
        drive(bubble_pct);
    endtask

    task automatic finish_run(input string tag);
        int n;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n = got_addr.size() - base;
        check({tag, "_nwrites"}, n, exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < n; k++) begin
            check({tag, "_addr"}, 32'(got_addr[base+k]), 32'(exp_addr[k]));
            check({tag, "_data"}, got_data[base+k], exp_data[k]);
        end
        check({tag, "_done"}, done, exp_done);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, exp_done);
        check({tag, "_in_ready"}, bus.in_ready, 0);
    endtask

    initial begin
        int cnt;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        apply_reset(1);

        // two words, back to back
        stim = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        start_run(0);
        finish_run("b2b");
        check("b2b_done_latency", done_rise_cyc - last_we_cyc, 1);

        // empty image
        apply_reset(0);
        stim = '{8'h00, 8'h00};
        start_run(0);
        check("hdr0_done_next", done, 1);
        check("hdr0_ready_next", bus.in_ready, 0);
        finish_run("hdr0");

        // oversized header
        apply_reset(0);
        stim = '{8'h01, 8'h04};
        start_run(0);
        check("ovf_error_next", error, 1);
        finish_run("ovf");

        // exactly DEPTH words
        apply_reset(0);
        stim = '{8'h00, 8'h04};
        for (int k = 0; k < 4 * DEPTH; k++) stim.push_back(8'($urandom));
        start_run(0);
        finish_run("full");
        check("full_last_addr", 32'(got_addr[got_addr.size()-1]), DEPTH - 1);

        // same two words with bubbles
        apply_reset(0);
        stim = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        start_run(50);
        finish_run("bubble");

        // random images with random bubbles
        for (int r = 0; r < 5; r++) begin
            apply_reset(0);
            cnt  = $urandom_range(1, 7);
            stim = '{8'(cnt), 8'h00};
            for (int k = 0; k < 4 * cnt; k++) stim.push_back(8'($urandom));
            start_run($urandom_range(0, 70));
            finish_run("rand");
        end

        // reset in the middle of word 1
        apply_reset(0);
        stim = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
        base = got_addr.size();
        drive(0);
        repeat (2) @(posedge clk);
        check("mid_nwrites", got_addr.size() - base, 1);
        check("mid_word0", got_data[base], 32'h12345678);
        apply_reset(1);
        stim = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        start_run(0);
        finish_run("after_rst");
        check("after_rst_word", got_data[got_data.size()-1], 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
